// File: rtl/dotp_serial_ctrl.sv
// Sequencer for the bit-serial dot-product datapath: takes an operand pair, pulses start,
// streams {B, A} LSB-first, then captures the result (or a timeout) and hands it downstream.
module dotp_serial_ctrl #(
  parameter int unsigned VEC_W   = 64,
  parameter int unsigned RES_W   = 19,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [VEC_W-1:0] in_a,
  input  logic [VEC_W-1:0] in_b,
  output logic             dp_start,
  output logic             dp_serial,
  input  logic [RES_W-1:0] dp_result,
  input  logic             dp_done,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RES_W-1:0] out_result,
  output logic             out_timeout,
  output logic             busy
);

  localparam int unsigned FRAME_W = 2 * VEC_W;
  localparam int unsigned BIT_W   = $clog2(FRAME_W);
  localparam int unsigned TMO_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [BIT_W-1:0] LastBit = BIT_W'(FRAME_W - 1);
  localparam logic [TMO_W-1:0] LastTmo = TMO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {StIdle, StStart, StShift, StWait, StHold} state_e;

  state_e             state_q;
  logic [FRAME_W-1:0] shreg_q;
  logic [BIT_W-1:0]   bit_cnt_q;
  logic [TMO_W-1:0]   tmo_cnt_q;

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q     <= StIdle;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      tmo_cnt_q   <= '0;
      out_result  <= '0;
      out_timeout <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            shreg_q <= {in_b, in_a};
            state_q <= StStart;
          end
        end
        StStart: begin
          bit_cnt_q <= '0;
          state_q   <= StShift;
        end
        StShift: begin
          shreg_q <= {1'b0, shreg_q[FRAME_W-1:1]};
          if (bit_cnt_q == LastBit) begin
            tmo_cnt_q <= '0;
            state_q   <= StWait;
          end else begin
            bit_cnt_q <= bit_cnt_q + BIT_W'(1);
          end
        end
        StWait: begin
          // A done arriving on the expiry cycle still delivers the real result.
          if (dp_done) begin
            out_result  <= dp_result;
            out_timeout <= 1'b0;
            state_q     <= StHold;
          end else if (tmo_cnt_q == LastTmo) begin
            out_result  <= '0;
            out_timeout <= 1'b1;
            state_q     <= StHold;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
          end
        end
        StHold: begin
          if (out_ready) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign dp_start  = (state_q == StStart);
  assign dp_serial = (state_q == StShift) & shreg_q[0];
  assign out_valid = (state_q == StHold);
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_dotp_serial_ctrl.sv
// Directed bench for dotp_serial_ctrl: nominal, backpressure, timeout, spurious done,
// reset mid-frame and back-to-back transactions.
module tb_dotp_serial_ctrl;

  localparam int unsigned VEC_W   = 64;
  localparam int unsigned RES_W   = 19;
  localparam int unsigned TIMEOUT = 16;

  logic             clk;
  logic             Reset;
  logic             in_valid;
  logic             in_ready;
  logic [VEC_W-1:0] in_a;
  logic [VEC_W-1:0] in_b;
  logic             dp_start;
  logic             dp_serial;
  logic [RES_W-1:0] dp_result;
  logic             dp_done;
  logic             out_valid;
  logic             out_ready;
  logic [RES_W-1:0] out_result;
  logic             out_timeout;
  logic             busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  dotp_serial_ctrl #(
    .VEC_W  (VEC_W),
    .RES_W  (RES_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk        (clk),
    .Reset      (Reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .dp_start   (dp_start),
    .dp_serial  (dp_serial),
    .dp_result  (dp_result),
    .dp_done    (dp_done),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_timeout(out_timeout),
    .busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Handshake an operand pair and check start pulse plus all 128 serial bits; optionally
  // pulse a spurious done in START and at bit 40. Returns in WAIT cycle 1.
  task automatic xfer(input logic [63:0] a, input logic [63:0] b, input bit spur);
    logic [127:0] frame;
    frame    = {b, a};
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("start_pulse", dp_start, 1);
    chk("start_busy", busy, 1);
    chk("start_in_ready", in_ready, 0);
    if (spur) begin
      dp_done   = 1'b1;
      dp_result = 19'h7ffff;
    end
    for (int i = 0; i < 128; i++) begin
      step();
      dp_done = 1'b0;
      chk($sformatf("serial%0d", i), dp_serial, frame[i]);
      if (i == 0 || i == 127) chk($sformatf("nostart%0d", i), dp_start, 0);
      if (spur && i == 40) begin
        dp_done   = 1'b1;
        dp_result = 19'h7ffff;
      end
    end
    step();
    dp_done = 1'b0;
    chk("wait_busy", busy, 1);
    chk("wait_serial0", dp_serial, 0);
    chk("wait_no_valid", out_valid, 0);
  endtask

  // From WAIT cycle 1, assert done in WAIT cycle n and check the captured result.
  task automatic done_at(input int n, input logic [RES_W-1:0] res);
    repeat (n - 1) step();
    chk("pre_done_no_valid", out_valid, 0);
    dp_done   = 1'b1;
    dp_result = res;
    step();
    dp_done   = 1'b0;
    dp_result = '0;
    chk("done_valid", out_valid, 1);
    chk("done_result", out_result, res);
    chk("done_timeout", out_timeout, 0);
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("rel_valid", out_valid, 0);
    chk("rel_in_ready", in_ready, 1);
    chk("rel_busy", busy, 0);
  endtask

  initial begin
    int n;
    Reset     = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    dp_result = '0;
    dp_done   = 1'b0;
    out_ready = 1'b0;
    step();
    step();
    Reset = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_start", dp_start, 0);
    chk("rst_serial", dp_serial, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_result", out_result, 0);
    chk("rst_timeout", out_timeout, 0);

    // Nominal
    xfer(64'h123456789abcdef0, 64'hfedcba9876543210, 1'b0);
    done_at(12, 19'h5a5a5);

    // Backpressure in HOLD with in_valid toggling
    for (int i = 0; i < 20; i++) begin
      in_valid = i[0];
      step();
      chk("bp_valid", out_valid, 1);
      chk("bp_result", out_result, 19'h5a5a5);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_no_start", dp_start, 0);
    end
    in_valid = 1'b0;
    release_result();

    // Timeout: no done ever, expiry 16 cycles after WAIT entry
    xfer(64'h0f0f0f0f0f0f0f0f, 64'h8000000000000001, 1'b0);
    repeat (15) step();
    chk("tmo_early", out_valid, 0);
    step();
    chk("tmo_valid", out_valid, 1);
    chk("tmo_flag", out_timeout, 1);
    chk("tmo_result", out_result, 0);
    release_result();

    // Done on the expiry cycle wins
    xfer(64'h0123456789abcdef, 64'h1111111111111111, 1'b0);
    done_at(16, 19'h3c3c3);

    release_result();

    // Spurious done in START and SHIFT is ignored
    xfer(64'haaaaaaaaaaaaaaaa, 64'h5555555555555555, 1'b1);
    done_at(5, 19'h00123);
    release_result();

    // Reset mid-SHIFT at bit 60
    in_a     = 64'hffffffffffffffff;
    in_b     = 64'h0;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (61) step();
    chk("abort_bit60", dp_serial, 1);
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    chk("abort_serial", dp_serial, 0);
    chk("abort_busy", busy, 0);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_valid", out_valid, 0);
    chk("abort_result", out_result, 0);
    xfer(64'h123456789abcdef0, 64'hfedcba9876543210, 1'b0);
    done_at(12, 19'h5a5a5);
    release_result();

    // Back-to-back with in_valid and out_ready held high, done latency 3
    in_a      = 64'hdeadbeefcafef00d;
    in_b      = 64'h0badc0de12345678;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    chk("b2b_start1", dp_start, 1);
    repeat (128) step();
    step();
    chk("b2b_wait", busy, 1);
    repeat (2) step();
    dp_done   = 1'b1;
    dp_result = 19'h13579;
    step();
    dp_done   = 1'b0;
    chk("b2b_valid1", out_valid, 1);
    chk("b2b_result1", out_result, 19'h13579);
    n = 0;
    do begin
      step();
      n++;
    end while (dp_start !== 1'b1 && n < 10);
    chk("b2b_gap", n, 2);
    in_valid = 1'b0;
    repeat (128) step();
    step();
    repeat (2) step();
    dp_done   = 1'b1;
    dp_result = 19'h2468a;
    step();
    dp_done   = 1'b0;
    chk("b2b_valid2", out_valid, 1);
    chk("b2b_result2", out_result, 19'h2468a);
    step();
    chk("b2b_idle", out_valid, 0);
    chk("b2b_in_ready", in_ready, 1);
    out_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dotp_serial_ctrl.md
Name: dotp_serial_ctrl

Overview:
Sequencer for the bit-serial dot-product datapath (8 x 8-bit elements, 19-bit result). It accepts one parallel operand pair (A, B) over a valid/ready handshake, issues the one-cycle Start pulse, and streams the 128-bit word {B, A} LSB-first on the serial line. It then waits for Done, captures DataOut, and presents the result downstream over a valid/ready handshake. A timeout guards against a datapath that never asserts Done.

Parameters:
VEC_W, 64, width of each operand vector; serial frame is 2*VEC_W bits
RES_W, 19, width of datapath result
TIMEOUT, 1023, maximum cycles spent waiting for dp_done (>=1)

Ports:
clk  input  1  system clock, rising edge
Reset  input  1  synchronous, active-high reset
in_valid  input  1  operand pair valid
in_ready  output  1  controller can accept operands
in_a  input  VEC_W  operand A, element 0 in bits [7:0]
in_b  input  VEC_W  operand B
dp_start  output  1  Start pulse to datapath
dp_serial  output  1  serial operand bit to datapath
dp_result  input  RES_W  datapath DataOut
dp_done  input  1  datapath Done
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_result  output  RES_W  captured result
out_timeout  output  1  result is a timeout, not a datapath value
busy  output  1  high in any state other than IDLE

Behaviour:
- One clock domain (clk); Reset synchronous, active-high, priority over everything.
- Reset values: state IDLE, in_ready=1 the cycle after reset, dp_start=0, dp_serial=0, out_valid=0, out_result=0, out_timeout=0, busy=0; shift register and counters cleared.
- States: IDLE, START, SHIFT, WAIT, HOLD.
- IDLE: in_ready=1. On in_valid && in_ready at edge: load shreg <= {in_b, in_a}, go START.
- START: exactly one cycle; dp_start=1, dp_serial=0. Go SHIFT, bit counter=0.
- SHIFT: dp_serial=shreg[0]. shreg shifts right one bit per cycle, zero-fill. Lasts exactly 2*VEC_W cycles, in order: A[0]..A[VEC_W-1], B[0]..B[VEC_W-1]. After the last bit, go WAIT. dp_serial=0 in every other state.
- WAIT: timeout counter cleared on entry and incremented each cycle.
  - If dp_done=1 at an edge: out_result <= dp_result, out_timeout <= 0, go HOLD.
  - Otherwise, if the counter reaches TIMEOUT-1: out_result <= 0, out_timeout <= 1, go HOLD.
  - If dp_done and expiry occur in the same cycle, dp_done wins.
- dp_done in IDLE, START, SHIFT or HOLD is ignored.
- A multi-cycle dp_done is captured once only, on the first WAIT cycle in which it is seen.
- HOLD: out_valid=1. out_result and out_timeout are held stable. On out_ready=1 at an edge: go IDLE, and out_valid drops the next cycle.
- in_ready=1 only in IDLE; in_valid in any other state is ignored.
- Latency, with the operand handshake at edge 0:
  - dp_start high in cycle 1.
  - Serial bits in cycles 2..129.
  - WAIT begins at cycle 130.
  - If dp_done is sampled at edge k, out_valid is high from cycle k+1.
- Back-to-back: if the result handshake occurs at edge h, in_ready=1 in cycle h+1. The next dp_start is no earlier than cycle h+2.
- Reset in any state, including mid-SHIFT or during HOLD: the current transaction is aborted with no output. The next cycle shows reset values.
- busy = (state != IDLE).

Test Plan:
- Nominal: after Reset, drive in_a=64'h123456789abcdef0 and in_b=64'hfedcba9876543210 with in_valid. Required: dp_start=1 for exactly one cycle (cycle 1); the 128 dp_serial bits in cycles 2..129 equal {in_b,in_a} LSB-first (first bit 0, bit 64 = 0). The model asserts dp_done 12 cycles into WAIT with dp_result=19'h5A5A5. Required: out_valid=1 the next cycle with out_result=19'h5A5A5 and out_timeout=0.
- Backpressure: hold out_ready=0 for 20 cycles in HOLD and toggle in_valid. Required: out_valid stays 1, out_result stays constant, in_ready=0, no dp_start; raising out_ready then returns to IDLE, with in_ready=1 one cycle later.
- Timeout with TIMEOUT=16 and dp_done never asserted: required out_valid exactly 16 cycles after WAIT entry, with out_timeout=1 and out_result=0. Separately, dp_done on cycle 16 of WAIT: required capture of the result with out_timeout=0.
- Spurious done: pulse dp_done during START and at SHIFT bit 40 with dp_result=19'h7FFFF. Required: ignored, state unaffected. A later dp_done in WAIT with 19'h00123 gives out_result=19'h00123.
- Reset mid-SHIFT at bit 60: required next cycle dp_serial=0, busy=0, in_ready=1, out_valid=0. A following nominal transaction completes correctly.
- Back-to-back: in_valid and out_ready held at 1 across two transactions with done latency 3. Required: the second dp_start occurs exactly 2 cycles after the first result handshake edge.
